// File: rtl/jtdd_rom_arb_pkg.sv
// Shared types and constants for the graphics ROM arbiter: slot ids, FSM
// states, default region offsets and the rotating slot picker.
package jtdd_rom_arb_pkg;

  typedef enum logic [1:0] {
    SLOT_SCR  = 2'd0,
    SLOT_CHR  = 2'd1,
    SLOT_OBJ  = 2'd2,
    SLOT_NONE = 2'd3
  } slot_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  localparam logic [21:0] DEF_SCR_OFFSET = 22'h00000;
  localparam logic [21:0] DEF_CHR_OFFSET = 22'h20000;
  localparam logic [21:0] DEF_OBJ_OFFSET = 22'h28000;

  // First missing slot in scr->chr->obj order, starting just after last.
  function automatic slot_e pick_slot(input slot_e last, input logic [2:0] miss);
    logic [1:0] cand;
    pick_slot = SLOT_NONE;
    cand      = last;
    for (int k = 0; k < 3; k++) begin
      cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
      if (miss[cand] && (pick_slot == SLOT_NONE)) begin
        pick_slot = slot_e'(cand);
      end
    end
  endfunction

endpackage

// File: rtl/jtdd_rom_slot.sv
// One-word read cache for a single fetcher; flags a hit when the requested
// address matches the cached one.
module jtdd_rom_slot import jtdd_rom_arb_pkg::*; #(
  parameter int AW = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cs_i,
  input  logic [AW-1:0] addr_i,
  input  logic          we_i,
  input  logic [AW-1:0] fill_addr_i,
  input  logic [15:0]   fill_data_i,
  output logic [15:0]   data_o,
  output logic          ok_o,
  output logic          miss_o
);

  logic [AW-1:0] cache_addr_q;
  logic [15:0]   cache_data_q;
  logic          valid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cache_addr_q <= '0;
      cache_data_q <= 16'h0000;
      valid_q      <= 1'b0;
    end else if (we_i) begin
      cache_addr_q <= fill_addr_i;
      cache_data_q <= fill_data_i;
      valid_q      <= 1'b1;
    end
  end

  assign ok_o   = cs_i && valid_q && (addr_i == cache_addr_q);
  assign miss_o = cs_i && !ok_o;
  assign data_o = cache_data_q;

endmodule

// File: rtl/jtdd_rom_arb.sv
// Shares one 16-bit ROM read port between scroll, char and object fetchers,
// serving cache misses one at a time in round-robin order.
module jtdd_rom_arb import jtdd_rom_arb_pkg::*; #(
  parameter int                 ROM_AW     = 22,
  parameter int                 SCR_AW     = 17,
  parameter int                 CHR_AW     = 15,
  parameter int                 OBJ_AW     = 18,
  parameter logic [ROM_AW-1:0]  SCR_OFFSET = ROM_AW'(DEF_SCR_OFFSET),
  parameter logic [ROM_AW-1:0]  CHR_OFFSET = ROM_AW'(DEF_CHR_OFFSET),
  parameter logic [ROM_AW-1:0]  OBJ_OFFSET = ROM_AW'(DEF_OBJ_OFFSET)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SCR_AW-1:0] scr_addr,
  input  logic              scr_cs,
  output logic [15:0]       scr_data,
  output logic              scr_ok,
  input  logic [CHR_AW-1:0] chr_addr,
  input  logic              chr_cs,
  output logic [15:0]       chr_data,
  output logic              chr_ok,
  input  logic [OBJ_AW-1:0] obj_addr,
  input  logic              obj_cs,
  output logic [15:0]       obj_data,
  output logic              obj_ok,
  output logic [ROM_AW-1:0] rom_addr,
  output logic              rom_req,
  input  logic              rom_ack,
  input  logic              rom_rdy,
  input  logic [15:0]       rom_dout
);

  localparam int LAT_AW = (SCR_AW > CHR_AW) ? ((SCR_AW > OBJ_AW) ? SCR_AW : OBJ_AW)
                                            : ((CHR_AW > OBJ_AW) ? CHR_AW : OBJ_AW);

  state_e              state_q, state_d;
  slot_e               slot_q, slot_d;
  slot_e               last_q, last_d;
  slot_e               next_slot_s;
  logic [LAT_AW-1:0]   lat_addr_q, lat_addr_d;
  logic                rom_req_q, rom_req_d;
  logic [ROM_AW-1:0]   rom_addr_q, rom_addr_d;
  logic [2:0]          miss_s;
  logic [2:0]          we_s;
  logic                fill_s;

  jtdd_rom_slot #(.AW(SCR_AW)) u_scr (
    .clk(clk), .rst(rst), .cs_i(scr_cs), .addr_i(scr_addr), .we_i(we_s[0]),
    .fill_addr_i(lat_addr_q[SCR_AW-1:0]), .fill_data_i(rom_dout),
    .data_o(scr_data), .ok_o(scr_ok), .miss_o(miss_s[0])
  );

  jtdd_rom_slot #(.AW(CHR_AW)) u_chr (
    .clk(clk), .rst(rst), .cs_i(chr_cs), .addr_i(chr_addr), .we_i(we_s[1]),
    .fill_addr_i(lat_addr_q[CHR_AW-1:0]), .fill_data_i(rom_dout),
    .data_o(chr_data), .ok_o(chr_ok), .miss_o(miss_s[1])
  );

  jtdd_rom_slot #(.AW(OBJ_AW)) u_obj (
    .clk(clk), .rst(rst), .cs_i(obj_cs), .addr_i(obj_addr), .we_i(we_s[2]),
    .fill_addr_i(lat_addr_q[OBJ_AW-1:0]), .fill_data_i(rom_dout),
    .data_o(obj_data), .ok_o(obj_ok), .miss_o(miss_s[2])
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      slot_q     <= SLOT_NONE;
      last_q     <= SLOT_OBJ;
      lat_addr_q <= '0;
      rom_req_q  <= 1'b0;
      rom_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      last_q     <= last_d;
      lat_addr_q <= lat_addr_d;
      rom_req_q  <= rom_req_d;
      rom_addr_q <= rom_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    last_d      = last_q;
    lat_addr_d  = lat_addr_q;
    rom_req_d   = rom_req_q;
    rom_addr_d  = rom_addr_q;
    fill_s      = 1'b0;
    next_slot_s = pick_slot(last_q, miss_s);
    case (state_q)
      ST_IDLE: begin
        if (next_slot_s != SLOT_NONE) begin
          state_d   = ST_REQ;
          slot_d    = next_slot_s;
          rom_req_d = 1'b1;
          case (next_slot_s)
            SLOT_SCR: begin
              lat_addr_d = LAT_AW'(scr_addr);
              rom_addr_d = SCR_OFFSET + ROM_AW'(scr_addr);
            end
            SLOT_CHR: begin
              lat_addr_d = LAT_AW'(chr_addr);
              rom_addr_d = CHR_OFFSET + ROM_AW'(chr_addr);
            end
            SLOT_OBJ: begin
              lat_addr_d = LAT_AW'(obj_addr);
              rom_addr_d = OBJ_OFFSET + ROM_AW'(obj_addr);
            end
            default: begin
              lat_addr_d = lat_addr_q;
              rom_addr_d = rom_addr_q;
            end
          endcase
        end else begin
          rom_req_d = 1'b0;
        end
      end
      ST_REQ: begin
        if (rom_ack) begin
          rom_req_d = 1'b0;
          // ack and rdy together complete the fetch without visiting WAIT
          if (rom_rdy) begin
            fill_s  = 1'b1;
            state_d = ST_IDLE;
            last_d  = slot_q;
          end else begin
            state_d = ST_WAIT;
          end
        end else begin
          rom_req_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (rom_rdy) begin
          fill_s  = 1'b1;
          state_d = ST_IDLE;
          last_d  = slot_q;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        rom_req_d = 1'b0;
      end
    endcase
  end

  assign we_s[0]  = fill_s && (slot_q == SLOT_SCR);
  assign we_s[1]  = fill_s && (slot_q == SLOT_CHR);
  assign we_s[2]  = fill_s && (slot_q == SLOT_OBJ);
  assign rom_req  = rom_req_q;
  assign rom_addr = rom_addr_q;

endmodule
